cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Responder side of the cache-to-memory control interface.
- Accepts instruction-fetch reads (iREN/iaddr) and data reads/writes (dREN/dWEN/daddr/dstore) from the L1 caches of CPUS cores.
- Serialises these requests onto the single RAM port.
- Returns wait/load to the granted cache. All other requesters are held in wait.

Parameters:
- CPUS, 2: number of cores; each core has one icache and one dcache requester.
- ADDR_W, 32: address width; word_t is 32 bits.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  CPUS  per-core instruction read request.
- iaddr  in  CPUS x 32  per-core instruction word address.
- iwait  out  CPUS  per-core instruction wait; 0 means iload is valid this cycle.
- iload  out  CPUS x 32  per-core instruction read data.
- dREN  in  CPUS  per-core data read request.
- dWEN  in  CPUS  per-core data write request.
- daddr  in  CPUS x 32  per-core data address.
- dstore  in  CPUS x 32  per-core write data.
- dwait  out  CPUS  per-core data wait; 0 means read data is valid or the write is done.
- dload  out  CPUS x 32  per-core data read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramready  in  1  RAM access complete this cycle.

Behaviour:
- Reset (nRST=0 at an edge):
  - state=IDLE, grant registers and rr_ptr cleared to 0.
  - iwait=dwait=all 1s; iload=dload=0.
  - ramREN=ramWEN=0; ramaddr=ramstore=0.
- Reset asserted mid-transaction aborts it with no completion signalled. The RAM strobes drop in the cycle after the reset edge.
- States: IDLE, BUSY.
- IDLE:
  - Scan requesters and latch winner id, kind (I-read / D-read / D-write), address and store data. Go to BUSY next cycle.
  - Within one core, data has priority over instruction. If dREN and dWEN are both asserted, the write wins.
  - Between cores, the priority order is set by ARB_* (see Optional Feature).
  - With no request, stay in IDLE. RAM strobes stay 0.
- BUSY:
  - Drive ramREN or ramWEN, ramaddr and ramstore from the latched registers (registered outputs).
  - When ramready=1: combinationally drive the granted wait bit to 0 and the granted load to ramload (reads) in the same cycle, then return to IDLE.
  - Only one wait bit is ever 0 in any cycle.
- Latency: a request sampled in IDLE at edge N is seen by RAM from cycle N+1. The earliest wait=0 is in cycle N+1, if ramready=1 immediately. The requester is freed for a new grant in the cycle after completion.
- Requesters must hold REN/WEN, address and data stable until their wait goes 0.
- If the granted requester drops its strobe while BUSY, the transaction is abandoned:
  - return to IDLE next cycle;
  - wait stays 1 and nothing is returned to that requester;
  - the RAM strobes deassert.
- Requests arriving while BUSY are not sampled until the next IDLE.
- A requester that completes and re-requests in the following cycle competes normally.
- Load outputs of non-granted requesters are 0.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin between cores.
  - rr_ptr points at the highest-priority core. Search order is rr_ptr, rr_ptr+1, ... modulo CPUS.
  - On each completed grant, rr_ptr becomes (granted core + 1) mod CPUS. The wrap from CPUS-1 gives 0.
  - Abandoned transactions do not move rr_ptr.
- Undefined: fixed priority, lowest core index first. rr_ptr logic is absent.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with iREN[0]=1 -> iwait=2'b11, dwait=2'b11, ramREN=0. First ramREN=1 is one cycle after nRST rises; ramaddr=iaddr[0].
- Single I-fetch: iREN[0]=1, iaddr[0]=0x0000_0040, ramready one cycle after ramREN with ramload=0xDEAD_BEEF -> iwait[0]=0 for exactly one cycle with iload[0]=0xDEAD_BEEF, then IDLE.
- Intra-core priority: dREN[0]=1 daddr=0x100 and iREN[0]=1 iaddr=0x40 together -> daddr served first (ramaddr=0x100). The I-fetch is served on the next grant; iwait[0] stays 1 meanwhile.
- Write: dWEN[1]=1, daddr=0x200, dstore=0x1234_5678 -> ramWEN=1 with ramstore=0x1234_5678. dwait[1]=0 on ramready; dload[1]=0.
- Arbitration, both cores continuously requesting iREN, ramready always 1:
  - with ARB_RR_EN: grants alternate 0,1,0,1;
  - without it: core 0 is granted every time.
- Abort: grant core 0 read, drop iREN[0] before ramready -> ramREN deasserts next cycle, iwait[0] never 0. A pending iREN[1] is granted next.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-memory bus: per-core icache/dcache request lanes plus the single shared RAM port.
// slave = arbiter side, master = caches and RAM side.
interface cache_mem_arbiter_if #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
);
  logic [CPUS-1:0]             iREN;
  logic [CPUS-1:0][ADDR_W-1:0] iaddr;
  logic [CPUS-1:0]             iwait;
  logic [CPUS-1:0][31:0]       iload;
  logic [CPUS-1:0]             dREN;
  logic [CPUS-1:0]             dWEN;
  logic [CPUS-1:0][ADDR_W-1:0] daddr;
  logic [CPUS-1:0][31:0]       dstore;
  logic [CPUS-1:0]             dwait;
  logic [CPUS-1:0][31:0]       dload;
  logic                        ramREN;
  logic                        ramWEN;
  logic [ADDR_W-1:0]           ramaddr;
  logic [31:0]                 ramstore;
  logic [31:0]                 ramload;
  logic                        ramready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises icache/dcache requests of CPUS cores onto one RAM port; one grant at a time.
// Between cores: fixed lowest-index priority, or round-robin when ARB_RR_EN is defined.
module cache_mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
) (
  input logic               CLK,
  input logic               nRST,
  cache_mem_arbiter_if.slave io_bus
);
  localparam int IDW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {K_IRD, K_DRD, K_DWR} kind_t;

  state_t            r_state;
  logic [IDW-1:0]    r_core;
  kind_t             r_kind;
  logic              r_ramREN;
  logic              r_ramWEN;
  logic [ADDR_W-1:0] r_ramaddr;
  logic [31:0]       r_ramstore;
`ifdef ARB_RR_EN
  logic [IDW-1:0]    r_rr_ptr;
`endif

  logic              w_found;
  logic [IDW-1:0]    w_core;
  logic [IDW-1:0]    w_sel;
  kind_t             w_kind;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_store;
  int                w_base;
  logic              w_still;
  logic              w_done;
  logic              w_abort;
  logic [CPUS-1:0]       w_iwait;
  logic [CPUS-1:0]       w_dwait;
  logic [CPUS-1:0][31:0] w_iload;
  logic [CPUS-1:0][31:0] w_dload;

  // Scan cores from the highest-priority one; within a core write > data read > fetch.
  always_comb begin
    w_found = 1'b0;
    w_core  = '0;
    w_sel   = '0;
    w_kind  = K_IRD;
    w_addr  = '0;
    w_store = '0;
`ifdef ARB_RR_EN
    w_base  = int'(r_rr_ptr);
`else
    w_base  = 0;
`endif
    for (int k = 0; k < CPUS; k++) begin
      w_sel = IDW'((w_base + k) % CPUS);
      if (!w_found && (io_bus.dWEN[w_sel] || io_bus.dREN[w_sel] || io_bus.iREN[w_sel])) begin
        w_found = 1'b1;
        w_core  = w_sel;
        if (io_bus.dWEN[w_sel]) begin
          w_kind  = K_DWR;
          w_addr  = io_bus.daddr[w_sel];
          w_store = io_bus.dstore[w_sel];
        end else if (io_bus.dREN[w_sel]) begin
          w_kind  = K_DRD;
          w_addr  = io_bus.daddr[w_sel];
        end else begin
          w_kind  = K_IRD;
          w_addr  = io_bus.iaddr[w_sel];
        end
      end
    end
  end

  always_comb begin
    case (r_kind)
      K_DWR:   w_still = io_bus.dWEN[r_core];
      K_DRD:   w_still = io_bus.dREN[r_core];
      default: w_still = io_bus.iREN[r_core];
    endcase
  end

  // A completion is never signalled while reset is being applied.
  assign w_done  = nRST && (r_state == BUSY) && w_still && io_bus.ramready;
  assign w_abort = (r_state == BUSY) && !w_still;

  always_comb begin
    w_iwait = '1;
    w_dwait = '1;
    w_iload = '0;
    w_dload = '0;
    if (w_done) begin
      case (r_kind)
        K_IRD: begin
          w_iwait[r_core] = 1'b0;
          w_iload[r_core] = io_bus.ramload;
        end
        K_DRD: begin
          w_dwait[r_core] = 1'b0;
          w_dload[r_core] = io_bus.ramload;
        end
        default: w_dwait[r_core] = 1'b0;
      endcase
    end
  end

  assign io_bus.iwait    = w_iwait;
  assign io_bus.iload    = w_iload;
  assign io_bus.dwait    = w_dwait;
  assign io_bus.dload    = w_dload;
  assign io_bus.ramREN   = r_ramREN;
  assign io_bus.ramWEN   = r_ramWEN;
  assign io_bus.ramaddr  = r_ramaddr;
  assign io_bus.ramstore = r_ramstore;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_core     <= '0;
      r_kind     <= K_IRD;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
`ifdef ARB_RR_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= BUSY;
            r_core     <= w_core;
            r_kind     <= w_kind;
            r_ramREN   <= (w_kind != K_DWR);
            r_ramWEN   <= (w_kind == K_DWR);
            r_ramaddr  <= w_addr;
            r_ramstore <= w_store;
          end
        end
        BUSY: begin
          if (w_done || w_abort) begin
            r_state  <= IDLE;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
          end
`ifdef ARB_RR_EN
          // Only completed grants rotate priority; abandoned ones leave it alone.
          if (w_done) begin
            r_rr_ptr <= (r_core == IDW'(CPUS - 1)) ? '0 : r_core + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
